// File: rtl/spi_pkg.sv
// Shared constants and types for the SPI-slave register bridge.
package spi_pkg;

    localparam int HDR_BITS  = 16;
    localparam int DATA_BITS = 32;
    localparam int WR_BIT    = 15;
    localparam int CNT_W     = 6;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        HDR  = 2'b01,
        DATA = 2'b10
    } spi_state_e;

    // Value the bit counter holds on the final bit of a field of the given length.
    function automatic logic [CNT_W-1:0] cnt_last(input int bits);
        return CNT_W'(bits - 1);
    endfunction

endpackage

// File: rtl/spi_sync_edge.sv
// Multi-flop synchroniser for one asynchronous pin, with rise/fall pulses
// derived from the synchronised level.
module spi_sync_edge #(
    parameter int   SYNC_STAGES = 2,
    parameter logic RESET_VAL   = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q,
    output logic rise,
    output logic fall
);

    logic [SYNC_STAGES-1:0] stage_r;
    logic                   prev_r;

    // Synchroniser chain plus one-cycle history for edge detection.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stage_r <= {SYNC_STAGES{RESET_VAL}};
            prev_r  <= RESET_VAL;
        end else begin
            stage_r <= {stage_r[SYNC_STAGES-2:0], d};
            prev_r  <= stage_r[SYNC_STAGES-1];
        end
    end

    assign q    = stage_r[SYNC_STAGES-1];
    assign rise = q & ~prev_r;
    assign fall = ~q & prev_r;

endmodule

// File: rtl/spi_tb.sv
// SPI mode-0 slave giving an external master read/write access to a 32-bit
// register file: 16-bit header (R/W + index), then 32-bit words with auto-increment.
module spi_tb
    import spi_pkg::*;
#(
    parameter int NREGS       = 16,
    parameter int ADDR_W      = 4,
    parameter int SYNC_STAGES = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  spi_sclk,
    input  logic                  spi_cs_n,
    input  logic                  spi_mosi,
    output logic                  spi_miso,
    output logic [NREGS*32-1:0]   regs_o,
    output logic                  wr_pulse_o,
    output logic [ADDR_W-1:0]     wr_addr_o
);

    localparam logic [CNT_W-1:0] HDR_LAST  = cnt_last(HDR_BITS);
    localparam logic [CNT_W-1:0] DATA_LAST = cnt_last(DATA_BITS);

    logic sclk_q_s, sclk_rise_s, sclk_fall_s;
    logic cs_q_s, cs_rise_s, cs_fall_s;
    logic mosi_s, mosi_rise_s, mosi_fall_s;
    logic unused_s;

    spi_state_e state_r, state_next;

    logic [CNT_W-1:0]     bit_cnt_r;
    logic [DATA_BITS-1:0] shift_r;
    logic [DATA_BITS-1:0] shift_next_s;
    logic [DATA_BITS-1:0] tx_r;
    logic [ADDR_W-1:0]    addr_r;
    logic [ADDR_W-1:0]    hdr_addr_s;
    logic [ADDR_W-1:0]    addr_inc_s;
    logic                 is_wr_r;
    logic                 miso_r;
    logic [DATA_BITS-1:0] regs_r [NREGS];
    logic                 commit_r;
    logic [ADDR_W-1:0]    commit_addr_r;
    logic                 wr_pulse_r;
    logic [ADDR_W-1:0]    wr_addr_r;

    logic start_s, shift_en_s, hdr_done_s, word_done_s, tx_shift_s;

    spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_sclk (
        .clk(clk), .rst_n(rst_n), .d(spi_sclk),
        .q(sclk_q_s), .rise(sclk_rise_s), .fall(sclk_fall_s)
    );

    spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_sync_cs (
        .clk(clk), .rst_n(rst_n), .d(spi_cs_n),
        .q(cs_q_s), .rise(cs_rise_s), .fall(cs_fall_s)
    );

    spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_mosi (
        .clk(clk), .rst_n(rst_n), .d(spi_mosi),
        .q(mosi_s), .rise(mosi_rise_s), .fall(mosi_fall_s)
    );

    assign unused_s     = ^{sclk_q_s, cs_q_s, mosi_rise_s, mosi_fall_s};
    assign shift_next_s = {shift_r[DATA_BITS-2:0], mosi_s};
    assign hdr_addr_s   = shift_next_s[ADDR_W-1:0];
    assign addr_inc_s   = addr_r + ADDR_W'(1);

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_next;
        end
    end

    // Next-state and per-cycle strobes; a CS release overrides everything.
    always_comb begin
        state_next  = state_r;
        start_s     = 1'b0;
        shift_en_s  = 1'b0;
        hdr_done_s  = 1'b0;
        word_done_s = 1'b0;
        tx_shift_s  = 1'b0;
        if (cs_rise_s) begin
            state_next = IDLE;
        end else begin
            case (state_r)
                IDLE: begin
                    if (cs_fall_s) begin
                        state_next = HDR;
                        start_s    = 1'b1;
                    end else begin
                        state_next = IDLE;
                    end
                end
                HDR: begin
                    if (sclk_rise_s) begin
                        shift_en_s = 1'b1;
                        if (bit_cnt_r == HDR_LAST) begin
                            hdr_done_s = 1'b1;
                            state_next = DATA;
                        end else begin
                            state_next = HDR;
                        end
                    end else begin
                        state_next = HDR;
                    end
                end
                DATA: begin
                    if (sclk_rise_s) begin
                        shift_en_s  = 1'b1;
                        word_done_s = (bit_cnt_r == DATA_LAST);
                    end else begin
                        shift_en_s  = 1'b0;
                    end
                    if (sclk_fall_s && !is_wr_r) begin
                        tx_shift_s = 1'b1;
                    end else begin
                        tx_shift_s = 1'b0;
                    end
                end
                default: begin
                    state_next = IDLE;
                end
            endcase
        end
    end

    // RX shifter, bit counter, header decode, address stepping and TX shifter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shift_r   <= '0;
            bit_cnt_r <= '0;
            addr_r    <= '0;
            is_wr_r   <= 1'b0;
            tx_r      <= '0;
            miso_r    <= 1'b0;
        end else begin
            if (start_s) begin
                shift_r   <= '0;
                bit_cnt_r <= '0;
            end else if (shift_en_s) begin
                shift_r   <= shift_next_s;
                bit_cnt_r <= (hdr_done_s || word_done_s) ? '0 : bit_cnt_r + CNT_W'(1);
            end

            if (hdr_done_s) begin
                is_wr_r <= shift_next_s[WR_BIT];
                addr_r  <= hdr_addr_s;
                tx_r    <= regs_r[hdr_addr_s];
            end else if (word_done_s) begin
                addr_r <= addr_inc_s;
                if (!is_wr_r) begin
                    tx_r <= regs_r[addr_inc_s];
                end
            end else if (tx_shift_s) begin
                tx_r <= {tx_r[DATA_BITS-2:0], 1'b0};
            end

            if (state_next == IDLE) begin
                miso_r <= 1'b0;
            end else if (tx_shift_s) begin
                miso_r <= tx_r[DATA_BITS-1];
            end
        end
    end

    // Register file commit; the strobe trails the commit by one clk.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NREGS; i++) begin
                regs_r[i] <= '0;
            end
            commit_r      <= 1'b0;
            commit_addr_r <= '0;
            wr_pulse_r    <= 1'b0;
            wr_addr_r     <= '0;
        end else begin
            commit_r   <= 1'b0;
            wr_pulse_r <= commit_r;
            if (word_done_s && is_wr_r) begin
                regs_r[addr_r] <= shift_next_s;
                commit_r       <= 1'b1;
                commit_addr_r  <= addr_r;
            end
            if (commit_r) begin
                wr_addr_r <= commit_addr_r;
            end
        end
    end

    // Flatten the register array onto the output bus.
    always_comb begin
        regs_o = '0;
        for (int i = 0; i < NREGS; i++) begin
            regs_o[32*i +: 32] = regs_r[i];
        end
    end

    assign spi_miso   = miso_r;
    assign wr_pulse_o = wr_pulse_r;
    assign wr_addr_o  = wr_addr_r;

endmodule

// File: tb/tb_spi_tb.sv
// Directed bench for the SPI register bridge: acts as SPI master and keeps
// its own copy of the expected register file.
module tb_spi_tb;

    localparam int NREGS = 16;
    localparam int HALF  = 80;

    logic                clk = 1'b0;
    logic                rst_n = 1'b0;
    logic                spi_sclk = 1'b0;
    logic                spi_cs_n = 1'b1;
    logic                spi_mosi = 1'b0;
    logic                spi_miso;
    logic [NREGS*32-1:0] regs_o;
    logic                wr_pulse_o;
    logic [3:0]          wr_addr_o;

    int          tests_run = 0;
    int          tests_failed = 0;
    int          pulse_cnt = 0;
    logic [3:0]  last_addr = 4'd0;
    logic [31:0] exp_regs [NREGS];
    logic [63:0] rx;
    int          p0;

    spi_tb #(.NREGS(NREGS), .ADDR_W(4), .SYNC_STAGES(2)) dut (
        .clk(clk), .rst_n(rst_n), .spi_sclk(spi_sclk), .spi_cs_n(spi_cs_n),
        .spi_mosi(spi_mosi), .spi_miso(spi_miso), .regs_o(regs_o),
        .wr_pulse_o(wr_pulse_o), .wr_addr_o(wr_addr_o)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (wr_pulse_o) begin
            pulse_cnt = pulse_cnt + 1;
            last_addr = wr_addr_o;
        end
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        tests_run = tests_run + 1;
        if (got !== exp) begin
            tests_failed = tests_failed + 1;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic check_regs(input string tag);
        for (int i = 0; i < NREGS; i++) begin
            chk($sformatf("%s_reg%0d", tag, i), {32'd0, regs_o[32*i +: 32]}, {32'd0, exp_regs[i]});
        end
    endtask

    // Shift n bits MSB first; MISO is captured just before each rising edge.
    task automatic xfer(input logic [63:0] tx, input int n, output logic [63:0] rxd);
        rxd = 64'd0;
        for (int i = n - 1; i >= 0; i--) begin
            spi_mosi = tx[i];
            #HALF;
            rxd      = {rxd[62:0], spi_miso};
            spi_sclk = 1'b1;
            #HALF;
            spi_sclk = 1'b0;
        end
    endtask

    task automatic cs_lo();
        spi_cs_n = 1'b0;
        #HALF;
    endtask

    task automatic cs_hi();
        #HALF;
        spi_cs_n = 1'b1;
        #(2 * HALF);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        for (int i = 0; i < NREGS; i++) exp_regs[i] = 32'd0;
        #100;
        chk("rst_miso", {63'd0, spi_miso}, 64'd0);
        chk("rst_pulse", {63'd0, wr_pulse_o}, 64'd0);
        chk("rst_waddr", {60'd0, wr_addr_o}, 64'd0);
        rst_n = 1'b1;
        #100;
        check_regs("rst");

        // Single write to reg 13
        cs_lo(); xfer(64'hABCD_0052329F, 48, rx); cs_hi();
        exp_regs[13] = 32'h0052329F;
        check_regs("wr1");
        chk("wr1_pulses", 64'(pulse_cnt), 64'd1);
        chk("wr1_addr", {60'd0, last_addr}, 64'd13);

        // Second write to reg 7
        cs_lo(); xfer(64'hA007_00500C1A, 48, rx); cs_hi();
        exp_regs[7] = 32'h00500C1A;
        check_regs("wr2");
        chk("wr2_addr", {60'd0, last_addr}, 64'd7);

        // Burst write: reg 8 whole, reg 9 in two 16-bit pieces
        p0 = pulse_cnt;
        cs_lo();
        xfer(64'hF978_17F7AD08, 48, rx);
        xfer(64'h0000_0000_0000_DEAD, 16, rx);
        xfer(64'h0000_0000_0000_1234, 16, rx);
        cs_hi();
        exp_regs[8] = 32'h17F7AD08;
        exp_regs[9] = 32'hDEAD1234;
        check_regs("burst");
        chk("burst_pulses", 64'(pulse_cnt - p0), 64'd2);
        chk("burst_addr", {60'd0, last_addr}, 64'd9);

        // Read reg 0 while MOSI carries data that must be ignored
        p0 = pulse_cnt;
        cs_lo(); xfer(64'h0000_00112322, 48, rx); cs_hi();
        chk("rd0_data", {32'd0, rx[31:0]}, 64'd0);
        chk("rd0_pulses", 64'(pulse_cnt - p0), 64'd0);
        check_regs("rd0");

        // Read reg 13
        cs_lo(); xfer(64'h000D_00000000, 48, rx); cs_hi();
        chk("rd13_data", {32'd0, rx[31:0]}, 64'h0052329F);
        chk("rd13_miso_idle", {63'd0, spi_miso}, 64'd0);

        // Burst read reg 7 then reg 8
        cs_lo();
        xfer(64'h0007_00000000, 48, rx);
        chk("rdb_reg7", {32'd0, rx[31:0]}, 64'h00500C1A);
        xfer(64'd0, 32, rx);
        chk("rdb_reg8", {32'd0, rx[31:0]}, 64'h17F7AD08);
        cs_hi();

        // Aborted frame: header plus 8 data bits, then CS release
        p0 = pulse_cnt;
        cs_lo(); xfer(64'h0000_0000_00A0_03CA, 24, rx); cs_hi();
        check_regs("abort");
        chk("abort_pulses", 64'(pulse_cnt - p0), 64'd0);
        cs_lo(); xfer(64'h8003_CAFEF00D, 48, rx); cs_hi();
        exp_regs[3] = 32'hCAFEF00D;
        check_regs("after_abort");
        chk("after_abort_addr", {60'd0, last_addr}, 64'd3);

        // Burst across the top register wraps to reg 0
        cs_lo();
        xfer(64'h800F_0F0F0001, 48, rx);
        xfer(64'h0000_0000_1000_0000, 32, rx);
        cs_hi();
        exp_regs[15] = 32'h0F0F0001;
        exp_regs[0]  = 32'h10000000;
        check_regs("wrap");
        chk("wrap_addr", {60'd0, last_addr}, 64'd0);

        // Reset in the middle of a burst write
        cs_lo();
        xfer(64'h8005_55555555, 48, rx);
        xfer(64'h0000_0000_0000_AAAA, 16, rx);
        rst_n = 1'b0;
        #30;
        for (int i = 0; i < NREGS; i++) exp_regs[i] = 32'd0;
        check_regs("midrst");
        chk("midrst_miso", {63'd0, spi_miso}, 64'd0);
        chk("midrst_pulse", {63'd0, wr_pulse_o}, 64'd0);
        spi_cs_n = 1'b1;
        #100;
        rst_n = 1'b1;
        #200;
        p0 = pulse_cnt;
        cs_lo(); xfer(64'h8002_11223344, 48, rx); cs_hi();
        exp_regs[2] = 32'h11223344;
        check_regs("postrst");
        chk("postrst_pulses", 64'(pulse_cnt - p0), 64'd1);
        chk("postrst_addr", {60'd0, last_addr}, 64'd2);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/spi_tb.md
Name: spi_tb

Overview:
- SPI slave (mode 0, MSB first) bridging an external SPI master to an internal 32-bit register file. All logic runs on one system clock; the SPI pins are synchronised into that clock.
- Frame: 16-bit header (R/W + address), then 32-bit data words.
- Holding chip-select low continues the transfer as a burst with address auto-increment.
- Sits between the chip SPI pads and the accelerator control registers.

Parameters:
- NREGS, 16, number of 32-bit registers (power of 2).
- ADDR_W, 4, log2(NREGS); register index is header[ADDR_W-1:0].
- SYNC_STAGES, 2, synchroniser depth on spi_sclk, spi_cs_n and spi_mosi.

Ports:
- clk  in  1  system clock; must be at least 4x the SCLK frequency.
- rst_n  in  1  reset, asynchronous assert, active-low.
- spi_sclk  in  1  SPI clock; idle low.
- spi_cs_n  in  1  chip select, active-low.
- spi_mosi  in  1  master-out data.
- spi_miso  out  1  slave-out data; driven 0 when spi_cs_n is high.
- regs_o  out  NREGS*32  flattened register file; reg i is at [32*i+31:32*i].
- wr_pulse_o  out  1  one-clk strobe when a register is written.
- wr_addr_o  out  ADDR_W  index of the register written, valid with wr_pulse_o.

Behaviour:
- Reset: all registers = 0; spi_miso = 0; wr_pulse_o = 0; wr_addr_o = 0; FSM = IDLE; bit counter = 0.
- Synchronisation:
  - All three SPI inputs pass through SYNC_STAGES flops.
  - Rising and falling SCLK edges are detected on the synchronised signal.
- Sampling and driving: MOSI is sampled on SCLK rising edges; MISO changes on SCLK falling edges.
- FSM states: IDLE, HDR, DATA.
  - IDLE -> HDR on the synchronised CS falling edge; clears the shift register and bit counter.
  - HDR: shifts 16 bits. After the 16th rising edge, latch the header.
    - header[15] = 1 is a write, 0 is a read.
    - header[14:ADDR_W] is ignored.
    - addr = header[ADDR_W-1:0].
    - Go to DATA.
  - DATA, write: shift 32 bits. On the 32nd rising edge:
    - regs[addr] <= the shifted word.
    - wr_pulse_o = 1 for one clk on the following cycle; wr_addr_o = addr.
    - addr wraps to (addr+1) mod NREGS; the counter restarts and the FSM stays in DATA.
  - DATA, read: at header completion, regs[addr] is loaded into the TX shifter.
    - bit31 is driven on the next SCLK falling edge; one bit per falling edge after that, MSB first.
    - After 32 bits, addr increments (mod NREGS) and the next register is loaded.
    - Write data received during a read is ignored.
  - Any state -> IDLE on the synchronised CS rising edge.
    - A partial header or partial data word is discarded; no register changes.
    - spi_miso returns to 0.
- Burst: data words may arrive as one 32-bit chunk or as any split across SCLK runs (e.g. two 16-bit pieces), provided CS stays low; only the bit count matters.
- Reset mid-frame: immediately return to IDLE with all registers cleared. The frame in progress is lost; the next CS falling edge starts a new frame.
- CS toggled with no SCLK edges: no effect.
- regs_o reflects a register write on the same clk that the write commits (before wr_pulse_o).

Decomposition:
- Shared package spi_pkg:
  - HDR_BITS = 16, DATA_BITS = 32.
  - FSM state enum {IDLE, HDR, DATA}.
  - WR_BIT = 15.
- One natural sub-module, spi_sync_edge: synchroniser plus rise/fall detect for one input, instantiated three times.
- Register file and FSM remain in the top level.

Test Plan:
- Single write: 48 bits 0xABCD_0052329F, CS released -> regs[13] = 0x0052329F; one wr_pulse_o with wr_addr_o = 13; all other registers still 0.
- Second write: 0xA007_00500C1A -> regs[7] = 0x00500C1A.
- Burst write:
  - Stimulus: 0xF978_17F7AD08 with CS held, then 16-bit 0xDEAD (CS held), then 16-bit 0x1234, then CS released.
  - Expected: regs[8] = 0x17F7AD08; regs[9] = 0xDEAD1234; exactly two wr_pulse_o strobes.
- Read:
  - Header 0x0000 (read reg 0), 32 clocks with MOSI = 0x00112322 -> MISO returns 0x00000000; regs[0] unchanged.
  - After the single write above, header 0x000D -> MISO returns 0x0052329F.
- Aborted frame: CS released after 24 bits of header 0xA003 plus data -> regs[3] unchanged; no wr_pulse_o; the next full frame decodes correctly.
- Reset mid-burst: assert rst_n low during DATA -> regs_o = 0; spi_miso = 0; a new frame after reset writes correctly.
